rgb_to_hsv_stream: RTL and testbench

- Parametrised, pipelined successor of the vision pipeline's RGB-to-HSV converter.
- Converts PIX_PER_CLK pixels per beat from RGB (COLOUR_W bits per channel) to HSV:
  - hue in degrees, 0..359
  - saturation and value scaled to COLOUR_W bits
- Adds a ready/valid backpressure handshake and a sideband bus carried alongside the pixels (sop/eop/coordinates).
- Sits between the camera pixel stream and the colour-threshold stage.

---
 rtl/rgb_to_hsv_stream_if.sv | 31 +++
 rtl/rgb_to_hsv_stream.sv | 190 +++++++++++++++++++
 tb/tb_rgb_to_hsv_stream.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_to_hsv_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgb_to_hsv_stream_if                                                       |
// | Streaming RGB-in / HSV-out bus with ready/valid handshakes and sideband.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface rgb_to_hsv_stream_if #(
  parameter int COLOUR_W    = 8,
  parameter int PIX_PER_CLK = 1,
  parameter int SB_W        = 2
);
  logic [3*COLOUR_W*PIX_PER_CLK-1:0]     rgb_in;
  logic [SB_W-1:0]                       sb_in;
  logic                                  valid_in;
  logic                                  ready_in;
  logic [(9+2*COLOUR_W)*PIX_PER_CLK-1:0] hsv_out;
  logic [SB_W-1:0]                       sb_out;
  logic                                  valid_out;
  logic                                  ready_out;

  modport master (
    output rgb_in, sb_in, valid_in, ready_out,
    input  ready_in, hsv_out, sb_out, valid_out
  );

  modport slave (
    input  rgb_in, sb_in, valid_in, ready_out,
    output ready_in, hsv_out, sb_out, valid_out
  );
endinterface
`default_nettype wire

// File: rtl/rgb_to_hsv_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgb_to_hsv_stream                                                          |
// | 3-stage RGB->HSV converter, PIX_PER_CLK lanes, ready/valid with sideband.  |
// | Define RGB_HSV_ROUND_EN to round qh/qs to nearest instead of truncating.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rgb_to_hsv_stream #(
  parameter int COLOUR_W    = 8,
  parameter int PIX_PER_CLK = 1,
  parameter int SB_W        = 2
) (
  input wire clk,
  input wire rst,
  rgb_to_hsv_stream_if.slave bus
);

  localparam int c_in_px  = 3*COLOUR_W;
  localparam int c_out_px = 9 + 2*COLOUR_W;
  localparam int c_nh_w   = COLOUR_W + 7;
  localparam int c_ns_w   = 2*COLOUR_W + 1;
  localparam int c_full   = (1 << COLOUR_W) - 1;

  localparam logic [1:0] c_sel_r = 2'd0;
  localparam logic [1:0] c_sel_g = 2'd1;
  localparam logic [1:0] c_sel_b = 2'd2;

  logic            w_adv;
  logic            r_s1_vld, r_s2_vld, r_s3_vld;
  logic [SB_W-1:0] r_s1_sb, r_s2_sb, r_s3_sb;
  wire  [c_out_px*PIX_PER_CLK-1:0] w_hsv;

  // One global enable: the whole pipe stalls only when the output beat is held.
  assign w_adv        = bus.ready_out || !bus.valid_out;
  assign bus.ready_in = w_adv && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
      r_s1_sb  <= '0;
      r_s2_sb  <= '0;
      r_s3_sb  <= '0;
    end else if (w_adv) begin
      r_s1_vld <= bus.valid_in;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
      r_s1_sb  <= bus.sb_in;
      r_s2_sb  <= r_s1_sb;
      r_s3_sb  <= r_s2_sb;
    end
  end

  assign bus.valid_out = r_s3_vld;
  assign bus.sb_out    = r_s3_sb;
  assign bus.hsv_out   = w_hsv;

  for (genvar p = 0; p < PIX_PER_CLK; p++) begin : g_pix
    logic [COLOUR_W-1:0] w_r, w_g, w_b;
    logic [COLOUR_W-1:0] w_max, w_min, w_pos, w_neg;
    logic [1:0]          w_sel;

    logic [1:0]          r_s1_sel;
    logic [COLOUR_W-1:0] r_s1_max, r_s1_delta, r_s1_abs;
    logic                r_s1_neg;

    logic [c_nh_w-1:0]   w_h_num, w_h_bias;
    logic [c_ns_w-1:0]   w_s_num, w_s_bias;
    logic [6:0]          w_qh;
    logic [COLOUR_W-1:0] w_qs;

    logic [1:0]          r_s2_sel;
    logic [COLOUR_W-1:0] r_s2_max, r_s2_qs;
    logic [6:0]          r_s2_qh;
    logic                r_s2_neg;

    logic [9:0]          w_base, w_qh_ext, w_h;
    logic [c_out_px-1:0] r_s3_hsv;

    assign w_r = bus.rgb_in[p*c_in_px + 2*COLOUR_W +: COLOUR_W];
    assign w_g = bus.rgb_in[p*c_in_px + COLOUR_W   +: COLOUR_W];
    assign w_b = bus.rgb_in[p*c_in_px              +: COLOUR_W];

    // S1: max selection with R > G > B tie priority, then the signed hue term.
    always_comb begin
      w_sel = c_sel_r;
      w_max = w_r;
      if (w_r >= w_g && w_r >= w_b) begin
        w_sel = c_sel_r;
        w_max = w_r;
      end else if (w_g >= w_b) begin
        w_sel = c_sel_g;
        w_max = w_g;
      end else begin
        w_sel = c_sel_b;
        w_max = w_b;
      end
      w_min = w_r;
      if (w_g < w_min) w_min = w_g;
      if (w_b < w_min) w_min = w_b;
      case (w_sel)
        c_sel_g: begin w_pos = w_b; w_neg = w_r; end
        c_sel_b: begin w_pos = w_r; w_neg = w_g; end
        default: begin w_pos = w_g; w_neg = w_b; end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1_sel   <= c_sel_r;
        r_s1_max   <= '0;
        r_s1_delta <= '0;
        r_s1_abs   <= '0;
        r_s1_neg   <= 1'b0;
      end else if (w_adv) begin
        r_s1_sel   <= w_sel;
        r_s1_max   <= w_max;
        r_s1_delta <= w_max - w_min;
        r_s1_neg   <= (w_pos < w_neg);
        r_s1_abs   <= (w_pos < w_neg) ? (w_neg - w_pos) : (w_pos - w_neg);
      end
    end

    // S2: the two divides; delta==0 also covers max==0 so no divide by zero is used.
    always_comb begin
`ifdef RGB_HSV_ROUND_EN
      w_h_bias = c_nh_w'(r_s1_delta >> 1);
      w_s_bias = c_ns_w'(r_s1_max >> 1);
`else
      w_h_bias = '0;
      w_s_bias = '0;
`endif
      w_h_num = c_nh_w'(r_s1_abs) * c_nh_w'(60) + w_h_bias;
      w_s_num = c_ns_w'(r_s1_delta) * c_ns_w'(c_full) + w_s_bias;
      if (r_s1_delta == '0) begin
        w_qh = '0;
        w_qs = '0;
      end else begin
        w_qh = 7'(w_h_num / c_nh_w'(r_s1_delta));
        w_qs = COLOUR_W'(w_s_num / c_ns_w'(r_s1_max));
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s2_sel <= c_sel_r;
        r_s2_max <= '0;
        r_s2_qs  <= '0;
        r_s2_qh  <= '0;
        r_s2_neg <= 1'b0;
      end else if (w_adv) begin
        r_s2_sel <= r_s1_sel;
        r_s2_max <= r_s1_max;
        r_s2_qs  <= w_qs;
        r_s2_qh  <= w_qh;
        r_s2_neg <= r_s1_neg;
      end
    end

    // S3: sector offset, then wrap into 0..359.
    always_comb begin
      case (r_s2_sel)
        c_sel_g: w_base = 10'd120;
        c_sel_b: w_base = 10'd240;
        default: w_base = 10'd0;
      endcase
      w_qh_ext = {3'd0, r_s2_qh};
      if (!r_s2_neg)
        w_h = w_base + w_qh_ext;
      else if (w_qh_ext > w_base)
        w_h = w_base + 10'd360 - w_qh_ext;
      else
        w_h = w_base - w_qh_ext;
      if (w_h == 10'd360) w_h = 10'd0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s3_hsv <= '0;
      end else if (w_adv) begin
        r_s3_hsv <= {9'(w_h), r_s2_qs, r_s2_max};
      end
    end

    assign w_hsv[p*c_out_px +: c_out_px] = r_s3_hsv;
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_to_hsv_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rgb_to_hsv_stream                                                       |
// | Bench for rgb_to_hsv_stream: 8-bit single lane and 10-bit dual lane DUTs.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rgb_to_hsv_stream;

  typedef struct {
    logic [63:0] hsv;
    logic [1:0]  sb;
    int          cyc;
    bit          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  int          tests, fails, cyc;
  bit          lat_mode;
  exp_t        q8[$], q10[$];
  logic [63:0] log8[$], log10[$];
  logic [63:0] held8, held10;
  logic [1:0]  heldsb8, heldsb10;
  bit          hold8, hold10;
  logic [23:0] dir8 [0:6];
  logic [63:0] dir8_exp [0:6];

  rgb_to_hsv_stream_if #(.COLOUR_W(8),  .PIX_PER_CLK(1), .SB_W(2)) bus8 ();
  rgb_to_hsv_stream_if #(.COLOUR_W(10), .PIX_PER_CLK(2), .SB_W(2)) bus10 ();

  rgb_to_hsv_stream #(.COLOUR_W(8),  .PIX_PER_CLK(1), .SB_W(2)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
  rgb_to_hsv_stream #(.COLOUR_W(10), .PIX_PER_CLK(2), .SB_W(2)) dut10 (.clk(clk), .rst(rst), .bus(bus10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion straight from the colour-space rules, in plain integers.
  function automatic void ref_px(input int r, input int g, input int b, input int cw,
                                 output int h, output int s, output int v);
    int mx, mn, dd, base, delta, ad, qh, qs, full;
    full = (1 << cw) - 1;
    if (r >= g && r >= b) begin mx = r; dd = g - b; base = 0;   end
    else if (g >= b)      begin mx = g; dd = b - r; base = 120; end
    else                  begin mx = b; dd = r - g; base = 240; end
    mn = r;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
    delta = mx - mn;
    ad = (dd < 0) ? -dd : dd;
    if (delta == 0) begin
      qh = 0;
      qs = 0;
    end else begin
`ifdef RGB_HSV_ROUND_EN
      qh = (60 * ad + delta / 2) / delta;
      qs = (delta * full + mx / 2) / mx;
`else
      qh = (60 * ad) / delta;
      qs = (delta * full) / mx;
`endif
    end
    h = (dd >= 0) ? base + qh : base - qh;
    if (h < 0) h = h + 360;
    if (h == 360) h = 0;
    s = qs;
    v = mx;
  endfunction

  function automatic logic [63:0] ref8(input logic [23:0] rgb);
    int h, s, v;
    ref_px(int'(rgb[23:16]), int'(rgb[15:8]), int'(rgb[7:0]), 8, h, s, v);
    return {39'd0, 9'(h), 8'(s), 8'(v)};
  endfunction

  function automatic logic [63:0] ref10(input logic [59:0] rgb);
    logic [63:0] e;
    int h, s, v;
    e = '0;
    for (int p = 0; p < 2; p++) begin
      ref_px(int'(rgb[p*30+20 +: 10]), int'(rgb[p*30+10 +: 10]), int'(rgb[p*30 +: 10]), 10, h, s, v);
      e[p*29 +: 29] = {9'(h), 10'(s), 10'(v)};
    end
    return e;
  endfunction

  // Random channel biased toward 0 / mid / full so ties and greys show up.
  function automatic int rch(input int cw);
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 2)) * ((1 << cw) - 1) / 2;
    return int'($urandom_range(0, (1 << cw) - 1));
  endfunction

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst || (bus8.valid_out && !bus8.ready_out)) chk("ready_in8_low", 64'(bus8.ready_in), 64'd0);
    else if (!bus8.valid_out) chk("ready_in8_high", 64'(bus8.ready_in), 64'd1);
    if (hold8) begin
      chk("hold8_valid", 64'(bus8.valid_out), 64'd1);
      chk("hold8_hsv", 64'(bus8.hsv_out), held8);
      chk("hold8_sb", 64'(bus8.sb_out), 64'(heldsb8));
    end
    if (bus8.valid_out && bus8.ready_out) begin
      chk("unexpected8", 64'(q8.size() != 0), 64'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("hsv8", 64'(bus8.hsv_out), e.hsv);
        chk("sb8", 64'(bus8.sb_out), 64'(e.sb));
        if (e.lat) chk("latency8", 64'(cyc - e.cyc), 64'd3);
        log8.push_back(64'(bus8.hsv_out));
      end
    end
    if (bus8.valid_in && bus8.ready_in) q8.push_back('{ref8(bus8.rgb_in), bus8.sb_in, cyc, lat_mode});
    if (rst) q8.delete();
    hold8   = bus8.valid_out && !bus8.ready_out && !rst;
    held8   = 64'(bus8.hsv_out);
    heldsb8 = bus8.sb_out;

    if (rst || (bus10.valid_out && !bus10.ready_out)) chk("ready_in10_low", 64'(bus10.ready_in), 64'd0);
    else if (!bus10.valid_out) chk("ready_in10_high", 64'(bus10.ready_in), 64'd1);
    if (hold10) begin
      chk("hold10_hsv", 64'(bus10.hsv_out), held10);
      chk("hold10_sb", 64'(bus10.sb_out), 64'(heldsb10));
    end
    if (bus10.valid_out && bus10.ready_out) begin
      chk("unexpected10", 64'(q10.size() != 0), 64'd1);
      if (q10.size() != 0) begin
        e = q10.pop_front();
        chk("hsv10", 64'(bus10.hsv_out), e.hsv);
        chk("sb10", 64'(bus10.sb_out), 64'(e.sb));
        if (e.lat) chk("latency10", 64'(cyc - e.cyc), 64'd3);
        log10.push_back(64'(bus10.hsv_out));
      end
    end
    if (bus10.valid_in && bus10.ready_in) q10.push_back('{ref10(bus10.rgb_in), bus10.sb_in, cyc, lat_mode});
    if (rst) q10.delete();
    hold10   = bus10.valid_out && !bus10.ready_out && !rst;
    held10   = 64'(bus10.hsv_out);
    heldsb10 = bus10.sb_out;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; lat_mode = 1'b0; hold8 = 1'b0; hold10 = 1'b0;
    dir8[0] = {8'd98,  8'd135, 8'd124};
    dir8[1] = {8'd78,  8'd85,  8'd255};
    dir8[2] = {8'd251, 8'd152, 8'd50};
    dir8[3] = {8'd100, 8'd100, 8'd100};
    dir8[4] = {8'd0,   8'd0,   8'd0};
    dir8[5] = {8'd255, 8'd0,   8'd1};
    dir8[6] = {8'd255, 8'd0,   8'd128};
`ifdef RGB_HSV_ROUND_EN
    dir8_exp[0] = {39'd0, 9'd162, 8'd70, 8'd135};
`else
    dir8_exp[0] = {39'd0, 9'd162, 8'd69, 8'd135};
`endif
    dir8_exp[1] = {39'd0, 9'd238, 8'd177, 8'd255};
    dir8_exp[2] = {39'd0, 9'd30,  8'd204, 8'd251};
    dir8_exp[3] = {39'd0, 9'd0,   8'd0,   8'd100};
    dir8_exp[4] = {39'd0, 9'd0,   8'd0,   8'd0};
    dir8_exp[5] = {39'd0, 9'd0,   8'd255, 8'd255};
    dir8_exp[6] = {39'd0, 9'd330, 8'd255, 8'd255};

    rst = 1'b1;
    bus8.valid_in = 1'b0;  bus8.rgb_in = '0;  bus8.sb_in = '0;  bus8.ready_out = 1'b1;
    bus10.valid_in = 1'b0; bus10.rgb_in = '0; bus10.sb_in = '0; bus10.ready_out = 1'b1;
    repeat (3) cycle();
    chk("rst_valid8", 64'(bus8.valid_out), 64'd0);
    chk("rst_hsv8", 64'(bus8.hsv_out), 64'd0);
    chk("rst_sb8", 64'(bus8.sb_out), 64'd0);
    chk("rst_ready8", 64'(bus8.ready_in), 64'd0);
    chk("rst_valid10", 64'(bus10.valid_out), 64'd0);
    chk("rst_hsv10", 64'(bus10.hsv_out), 64'd0);

    // Directed colours back to back, first beat on the cycle after reset release.
    rst = 1'b0;
    lat_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus8.valid_in = 1'b1;
      bus8.rgb_in   = dir8[i];
      bus8.sb_in    = 2'(i);
      bus10.valid_in = (i == 0);
      bus10.rgb_in   = {10'd0, 10'd0, 10'd1023, 10'd1023, 10'd0, 10'd0};
      bus10.sb_in    = 2'd3;
      cycle();
    end
    bus8.valid_in = 1'b0;
    bus10.valid_in = 1'b0;
    repeat (5) cycle();
    lat_mode = 1'b0;
    chk("dir_count8", 64'(log8.size()), 64'd7);
    for (int i = 0; i < 7; i++)
      if (i < log8.size()) chk($sformatf("dir8_%0d", i), log8[i], dir8_exp[i]);
    chk("dir_count10", 64'(log10.size()), 64'd1);
    if (log10.size() > 0)
      chk("dir10_lanes", log10[0], {6'd0, 9'd240, 10'd1023, 10'd1023, 9'd0, 10'd1023, 10'd1023});

    // Backpressure: 5 stalled cycles mid-stream.
    for (int i = 0; i < 30; i++) begin
      bus8.valid_in  = 1'b1;
      bus8.rgb_in    = {8'(rch(8)), 8'(rch(8)), 8'(rch(8))};
      bus8.sb_in     = 2'($urandom);
      bus8.ready_out = !(i >= 10 && i < 15);
      cycle();
    end
    bus8.valid_in  = 1'b0;
    bus8.ready_out = 1'b1;
    repeat (8) cycle();
    chk("bp_drained8", 64'(q8.size()), 64'd0);

    // Random traffic with random backpressure on both instances.
    for (int i = 0; i < 400; i++) begin
      bus8.valid_in   = ($urandom_range(0, 3) != 0);
      bus8.rgb_in     = {8'(rch(8)), 8'(rch(8)), 8'(rch(8))};
      bus8.sb_in      = 2'($urandom);
      bus8.ready_out  = ($urandom_range(0, 9) < 7);
      bus10.valid_in  = ($urandom_range(0, 3) != 0);
      bus10.rgb_in    = {10'(rch(10)), 10'(rch(10)), 10'(rch(10)), 10'(rch(10)), 10'(rch(10)), 10'(rch(10))};
      bus10.sb_in     = 2'($urandom);
      bus10.ready_out = ($urandom_range(0, 9) < 7);
      cycle();
    end
    bus8.valid_in = 1'b0;  bus8.ready_out = 1'b1;
    bus10.valid_in = 1'b0; bus10.ready_out = 1'b1;
    repeat (10) cycle();
    chk("rand_drained8", 64'(q8.size()), 64'd0);
    chk("rand_drained10", 64'(q10.size()), 64'd0);

    // Reset with three beats in flight; none of them may emerge afterwards.
    bus8.ready_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus8.valid_in = 1'b1;
      bus8.rgb_in   = {8'(rch(8)), 8'(rch(8)), 8'(rch(8))};
      bus8.sb_in    = 2'(i);
      cycle();
    end
    chk("inflight_valid8", 64'(bus8.valid_out), 64'd1);
    bus8.valid_in = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_valid8", 64'(bus8.valid_out), 64'd0);
    bus8.ready_out = 1'b1;
    repeat (8) cycle();
    chk("rst_mid_empty8", 64'(q8.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
